// File: rtl/msk_sbox_pkg.sv
// Shared constants for the masked Skinny S-box sequencer: latency, control layout, schedule, S-box.
// SKINNY_SBOX is only consumed by the MSK_SBOX_SELFCHECK_EN build of msk_sbox_sched.
package msk_sbox_pkg;

   localparam int LAT    = 6;
   localparam int CTRL_W = 16;

   // sb_ctrl bit positions, MSB first
   localparam int CTRL_EN2    = 15;
   localparam int CTRL_EN3    = 14;
   localparam int CTRL_EN4    = 13;
   localparam int CTRL_EN5    = 12;
   localparam int CTRL_SEL1A1 = 11;
   localparam int CTRL_SEL2A1 = 10;
   localparam int CTRL_SEL1B1 = 9;
   localparam int CTRL_SEL2B1 = 8;
   localparam int CTRL_SEL1X1 = 7;
   localparam int CTRL_SEL2X1 = 6;
   localparam int CTRL_SEL1A2 = 5;
   localparam int CTRL_SEL1B2 = 4;
   localparam int CTRL_SEL1X2 = 3;
   localparam int CTRL_SEL2A2 = 2;
   localparam int CTRL_SEL2B2 = 1;
   localparam int CTRL_SEL2X2 = 0;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;
   typedef logic [CTRL_W-1:0] ctrl_t;

   localparam ctrl_t SCHED_IDLE = '0;

   // Gate 1 operands on k=0/1, gate 2 operands on k=2/3, second-layer mixing on k=4/5, final enable on k=6
   localparam logic [0:LAT][CTRL_W-1:0] SCHED = {
      16'h8A80, 16'h4540, 16'h2038, 16'h1007, 16'h8900, 16'h6014, 16'h1000
   };

   typedef logic [0:255][7:0] sbox_tbl_t;

   // Four NOR/XOR rounds with a bit permutation; the last round only swaps bits 1 and 2
   function automatic logic [7:0] skinny_sbox_eval(input logic [7:0] v);
      logic [7:0] x;
      x = v;
      for (int r = 0; r < 4; r++) begin
         x[4] = x[4] ^ ~(x[7] | x[6]);
         x[0] = x[0] ^ ~(x[3] | x[2]);
         if (r < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
         else       x = {x[7:3], x[1], x[2], x[0]};
      end
      return x;
   endfunction

   function automatic sbox_tbl_t build_sbox();
      sbox_tbl_t t;
      for (int i = 0; i < 256; i++) t[i] = skinny_sbox_eval(8'(i));
      return t;
   endfunction

   localparam sbox_tbl_t SKINNY_SBOX = build_sbox();

endpackage

// File: rtl/msk_byte_unmask.sv
// Folds the d shares of each bit of a shared byte back into the plain byte.
// Used only by the MSK_SBOX_SELFCHECK_EN simulation check.
module msk_byte_unmask #(
   parameter int d = 2
) (
   input  logic [8*d-1:0] shares,
   output logic [7:0]     value
);

   always_comb begin
      value = '0;
      for (int i = 0; i < 8; i++) value[i] = ^shares[d*i +: d];
   end

endmodule

// File: rtl/msk_sbox_sched.sv
// Sequencer for the masked Skinny 8-bit S-box core: accepts one shared byte, runs the 7-cycle
// control schedule with fresh randomness, captures the result. Macro MSK_SBOX_SELFCHECK_EN adds an unmasked check.
module msk_sbox_sched
   import msk_sbox_pkg::*;
#(
   parameter  int d    = 2,
   localparam int NRND = d * (d - 1) / 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [8*d-1:0]    in_data,
   input  logic              rnd_valid,
   input  logic [2*NRND-1:0] rnd_in,
   output logic              rnd_ready,
   output logic [2*NRND-1:0] sb_rnd,
   output logic [8*d-1:0]    sb_in,
   output logic [CTRL_W-1:0] sb_ctrl,
   input  logic [8*d-1:0]    sb_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [8*d-1:0]    out_data,
   output logic              err
);

   state_t     state_q, state_d;
   logic [2:0] k_q, k_d;
   logic       out_free, start, run_done, rnd_miss, chk_bad;

   assign out_free = !out_valid || out_ready;
   assign in_ready = !rst && (state_q == ST_IDLE) && rnd_valid && out_free;
   assign start    = in_valid && in_ready;
   assign run_done = (state_q == ST_RUN) && (k_q == 3'(LAT));
   assign sb_rnd   = rnd_ready ? rnd_in : '0;
   assign rnd_miss = rnd_ready && !rnd_valid;

   // NOTE: non-blocking assignments so every register samples the pre-edge values
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      sb_ctrl   = SCHED_IDLE;
      rnd_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               k_d     = '0;
            end
         end
         ST_RUN: begin
            // Core registers have no enable, so the schedule never stalls once started
            sb_ctrl   = SCHED[k_q];
            rnd_ready = (k_q < 3'(LAT));
            if (run_done) state_d = ST_IDLE;
            else          k_d     = k_q + 3'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef MSK_SBOX_SELFCHECK_EN
   logic [7:0] plain_in, plain_out;

   msk_byte_unmask #(.d(d)) u_unmask_in  (.shares(sb_in),  .value(plain_in));
   msk_byte_unmask #(.d(d)) u_unmask_out (.shares(sb_out), .value(plain_out));

   // Unmasked values only feed this comparison, never a port
   assign chk_bad = run_done && (SKINNY_SBOX[plain_in] != plain_out);
`else
   assign chk_bad = 1'b0;
`endif

   // NOTE: sb_in and out_data are reset too, so neither the core nor downstream ever sees stale shares
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_in     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         err       <= 1'b0;
      end else begin
         if (start) sb_in <= in_data;
         if (run_done) begin
            out_valid <= 1'b1;
            out_data  <= sb_out;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (rnd_miss || chk_bad) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_msk_sbox_sched.sv
// Bench for msk_sbox_sched (d=2): a cycle-level reference model plus a behavioural S-box core,
// checked every cycle, and directed scenarios with hand-computed S-box results.
module tb_msk_sbox_sched;

   localparam int D    = 2;
   localparam int NRND = D * (D - 1) / 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [8*D-1:0]    in_data = '0;
   logic              rnd_valid = 1'b1;
   logic [2*NRND-1:0] rnd_in = '0;
   logic              rnd_ready;
   logic [2*NRND-1:0] sb_rnd;
   logic [8*D-1:0]    sb_in;
   logic [15:0]       sb_ctrl;
   logic [8*D-1:0]    sb_out = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [8*D-1:0]    out_data;
   logic              err;

   int total = 0;
   int bad   = 0;
   int edge_cnt = 0;

   localparam logic [15:0] SCHED_TB [7] = '{
      16'h8A80, 16'h4540, 16'h2038, 16'h1007, 16'h8900, 16'h6014, 16'h1000
   };

   msk_sbox_sched #(.d(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rnd_valid (rnd_valid),
      .rnd_in    (rnd_in),
      .rnd_ready (rnd_ready),
      .sb_rnd    (sb_rnd),
      .sb_in     (sb_in),
      .sb_ctrl   (sb_ctrl),
      .sb_out    (sb_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err       (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   initial begin
      forever begin
         @(posedge clk);
         #1 rnd_in = 2'($urandom);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   function automatic logic [15:0] pack2(input logic [7:0] s0, input logic [7:0] s1);
      logic [15:0] r;
      for (int i = 0; i < 8; i++) begin
         r[2*i]   = s0[i];
         r[2*i+1] = s1[i];
      end
      return r;
   endfunction

   function automatic logic [7:0] unmask(input logic [15:0] s);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = s[2*i] ^ s[2*i+1];
      return r;
   endfunction

   // Skinny-128 8-bit S-box from its round definition, permutation given as a source-bit table
   function automatic logic [7:0] ref_sbox(input logic [7:0] v);
      int         src [8];
      logic [7:0] x, p;
      src = '{5, 3, 0, 4, 6, 7, 1, 2};
      x = v;
      for (int r = 0; r < 4; r++) begin
         x[4] ^= ~(x[7] | x[6]);
         x[0] ^= ~(x[3] | x[2]);
         p = x;
         if (r < 3) begin
            for (int j = 0; j < 8; j++) p[j] = x[src[j]];
         end else begin
            p[1] = x[2];
            p[2] = x[1];
         end
         x = p;
      end
      return x;
   endfunction

   // Reference model: m_acc is the edge at which the current byte was accepted (k = edges since then)
   int          m_acc  = -1;
   logic [15:0] m_sbin = '0;
   logic [15:0] m_od   = '0;
   logic        m_ov   = 1'b0;
   logic        m_err  = 1'b0;
   logic [7:0]  res_q [$];

   always @(negedge clk) begin
      int          k;
      bit          busy;
      logic        e_rr, e_ir;
      logic [7:0]  msk;
      logic [15:0] e_ctrl;
      k    = edge_cnt - m_acc;
      busy = (m_acc >= 0) && (k >= 0) && (k <= 6);
      msk  = 8'($urandom);
      // Core model: a freshly re-masked result only in cycle 6, garbage otherwise
      if (busy && k == 6) sb_out = pack2(ref_sbox(unmask(m_sbin)) ^ msk, msk);
      else                sb_out = 16'($urandom);
      e_ctrl = busy ? SCHED_TB[k] : 16'h0000;
      e_rr   = busy && (k <= 5);
      e_ir   = !rst && !busy && rnd_valid && (!m_ov || out_ready);
      if (edge_cnt >= 1) begin
         check("in_ready",  in_ready,  e_ir);
         check("rnd_ready", rnd_ready, e_rr);
         check("sb_rnd",    sb_rnd,    e_rr ? rnd_in : 2'b00);
         check("sb_ctrl",   sb_ctrl,   e_ctrl);
         check("sb_in",     sb_in,     m_sbin);
         check("out_valid", out_valid, m_ov);
         check("out_data",  out_data,  m_od);
         check("err",       err,       m_err);
      end
      if (out_valid && out_ready) res_q.push_back(unmask(out_data));
      if (rst) begin
         m_acc  = -1;
         m_sbin = '0;
         m_ov   = 1'b0;
         m_od   = '0;
         m_err  = 1'b0;
      end else begin
         if (e_rr && !rnd_valid) m_err = 1'b1;
         if (busy && k == 6) begin
            m_ov = 1'b1;
            m_od = sb_out;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         if (e_ir && in_valid) begin
            m_acc  = edge_cnt + 1;
            m_sbin = in_data;
         end
      end
   end

   // Presents data until accepted; returns the accept edge and leaves the caller in RUN k=0
   task automatic send(input logic [15:0] data, output int acc);
      acc = -1;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = data;
      for (int i = 0; i < 40 && acc < 0; i++) begin
         @(negedge clk);
         if (in_ready) acc = edge_cnt + 1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("accepted", acc >= 0, 1'b1);
   endtask

   task automatic wait_res(output logic [7:0] r);
      int got;
      got = 0;
      r   = 8'h00;
      for (int i = 0; i < 40 && got == 0; i++) begin
         if (res_q.size() > 0) got = 1;
         else @(negedge clk);
      end
      check("result_seen", got, 1);
      if (got != 0) r = res_q.pop_front();
   endtask

   initial begin
      int          a0, a1, lat;
      logic [7:0]  r;
      logic [15:0] held;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sb_ctrl",   sb_ctrl,   16'h0000);
      check("rst_err",       err,       1'b0);
      check("rst_in_ready",  in_ready,  1'b1);

      // 1: byte 0x00 as shares {5A,5A}
      send(pack2(8'h5A, 8'h5A), a0);
      lat = -1;
      for (int i = 0; i < 20 && lat < 0; i++) begin
         @(negedge clk);
         if (out_valid) lat = edge_cnt - a0;
      end
      check("t1_latency", lat, 7);
      wait_res(r);
      check("t1_result", r, 8'h65);

      // 2: byte 0xFF as shares {3C,C3}, schedule endpoints pinned by literals
      send(pack2(8'h3C, 8'hC3), a0);
      @(negedge clk);
      check("t2_ctrl_k0", sb_ctrl, 16'h8A80);
      repeat (6) @(negedge clk);
      check("t2_ctrl_k6", sb_ctrl, 16'h1000);
      @(negedge clk);
      check("t2_ctrl_idle", sb_ctrl, 16'h0000);
      wait_res(r);
      check("t2_result", r, 8'hFF);

      // 3: back-to-back 0x00, 0x01; seven RUN cycles with in_ready low, then one IDLE cycle
      send(pack2(8'h21, 8'h21), a0);
      send(pack2(8'h76, 8'h77), a1);
      check("t3_gap", a1 - a0, 8);
      wait_res(r);
      check("t3_result0", r, 8'h65);
      wait_res(r);
      check("t3_result1", r, 8'h4C);

      // 4: result held for 20 cycles with the next byte pending
      out_ready = 1'b0;
      send(pack2(8'h99, 8'h99), a0);
      in_valid = 1'b1;
      in_data  = pack2(8'h10, 8'h11);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      held = out_data;
      check("t4_held_value", unmask(held), 8'h65);
      repeat (20) begin
         @(negedge clk);
         check("t4_hold_data",     out_data, held);
         check("t4_hold_in_ready", in_ready, 1'b0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("t4_release_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_res(r);
      check("t4_result0", r, 8'h65);
      wait_res(r);
      check("t4_result1", r, 8'h4C);

      // 5: reset at RUN k=3 discards the run
      send(pack2(8'hA5, 8'hA4), a0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t5_sb_ctrl",   sb_ctrl,   16'h0000);
      check("t5_out_valid", out_valid, 1'b0);
      check("t5_err",       err,       1'b0);
      check("t5_in_ready",  in_ready,  1'b1);
      send(pack2(8'h0F, 8'hF0), a0);
      wait_res(r);
      check("t5_result", r, 8'hFF);
      check("t5_no_partial", res_q.size(), 0);

      // 6: randomness missing at k=2 sets a sticky err, run still completes
      send(pack2(8'h33, 8'h33), a0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rnd_valid = 1'b0;
      @(posedge clk);
      #1 rnd_valid = 1'b1;
      @(negedge clk);
      check("t6_err_set", err, 1'b1);
      wait_res(r);
      check("t6_result", r, 8'h65);
      send(pack2(8'h00, 8'hFF), a0);
      wait_res(r);
      check("t6_next_result", r, 8'hFF);
      check("t6_err_sticky", err, 1'b1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_err_cleared", err, 1'b0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
